// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with HI/LO result registers.
// Signed and unsigned mult/div over WIDTH-bit operands in WIDTH+1 cycles,
// using a start/busy/done handshake. Also services mthi/mtlo writes.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             MDU_start,
    input  logic [1:0]       MDU_op,
    input  logic [WIDTH-1:0] MDU_operand_1,
    input  logic [WIDTH-1:0] MDU_operand_2,
    input  logic             MDU_hi_we,
    input  logic             MDU_lo_we,
    output logic             MDU_busy,
    output logic             MDU_done,
    output logic             MDU_div_zero,
    output logic [WIDTH-1:0] MDU_hi,
    output logic [WIDTH-1:0] MDU_lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Operation context captured on the accepting edge.
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_res;    // quotient / product must be negated
    logic               neg_rem;    // dividend was negative (remainder sign)
    logic               zero_div;   // divide with a zero divisor
    logic [WIDTH-1:0]   mag_b;      // multiplicand / divisor magnitude
    // Mult: {partial product high, remaining multiplier bits}.
    // Div:  {partial remainder, remaining dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;

    // Input decode for the accepting edge.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic             b_zero;

    // One radix-2 step and the sign-corrected results.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Operand magnitudes and sign flags for the op being requested.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, else a latch is inferred.
        a_neg    = ~MDU_op[0] & MDU_operand_1[WIDTH-1];
        b_neg    = ~MDU_op[0] & MDU_operand_2[WIDTH-1];
        mag_a_in = a_neg ? -MDU_operand_1 : MDU_operand_1;
        mag_b_in = b_neg ? -MDU_operand_2 : MDU_operand_2;
        b_zero   = (MDU_operand_2 == '0);
    end

    // One shift-add (mult) or restoring shift-subtract (div) step on acc.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, mag_b});
        // Only used when div_ge, so the difference always fits in WIDTH bits.
        div_diff  = div_shift[WIDTH-1:0] - mag_b;
        if (is_div) begin
            step_acc = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        end else begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Final step plus sign correction; a zero divisor bypasses the datapath.
    always_comb begin
        prod = neg_res ? -step_acc : step_acc;
        quo  = step_acc[WIDTH-1:0];
        rem  = step_acc[2*WIDTH-1:WIDTH];
        if (zero_div) begin
            // acc still holds |dividend|; restoring the sign gives the raw operand.
            fix_hi = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = neg_rem ? -rem : rem;
            fix_lo = neg_res ? -quo : quo;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge SYS_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (SYS_reset) state <= IDLE;
        else           state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (MDU_start) next_state = (MDU_op[1] && b_zero) ? FIX : CALC;
            CALC: if (count == COUNT_LAST) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: busy for the whole of CALC and FIX.
    always_comb begin
        MDU_busy = (state != IDLE);
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            count        <= '0;
            is_div       <= 1'b0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            zero_div     <= 1'b0;
            mag_b        <= '0;
            acc          <= '0;
            MDU_hi       <= '0;
            MDU_lo       <= '0;
            MDU_done     <= 1'b0;
            MDU_div_zero <= 1'b0;
        end else begin
            MDU_done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (MDU_start) begin
                        count        <= COUNT_INIT;
                        is_div       <= MDU_op[1];
                        neg_res      <= a_neg ^ b_neg;
                        neg_rem      <= MDU_op[1] & a_neg;
                        zero_div     <= MDU_op[1] & b_zero;
                        mag_b        <= mag_b_in;
                        acc          <= {{WIDTH{1'b0}}, mag_a_in};
                        MDU_div_zero <= 1'b0;
                    end else begin
                        if (MDU_hi_we) MDU_hi <= MDU_operand_1;
                        if (MDU_lo_we) MDU_lo <= MDU_operand_1;
                    end
                end
                CALC: begin
                    acc   <= step_acc;
                    count <= count - CW'(1);
                end
                FIX: begin
                    MDU_hi       <= fix_hi;
                    MDU_lo       <= fix_lo;
                    MDU_div_zero <= zero_div;
                end
                default: ;
            endcase
        end
    end

endmodule
